asynch_fifo: RTL and testbench

Synchronous-interface FIFO buffer, 64 entries × 8 bits by default, with registered read data and full/empty status flags. It decouples a producer from a consumer that share one clock domain and stalls either side through the status flags. It sits between a data source and a sink and performs no data transformation.

---
 rtl/asynch_fifo_pkg.sv | 11 +
 rtl/fifo_mem.sv | 39 +++
 rtl/asynch_fifo.sv | 73 +++++++
 tb/tb_asynch_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/asynch_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO slice.
package asynch_fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 64;
    localparam int ADDR_WIDTH = 6;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// synchronous read port with a registered output. The array itself is not reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Store write data; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read data; cleared by reset, held when no read is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/asynch_fifo.sv
// Single-clock FIFO: pointers, occupancy counter, flag decode and acceptance
// logic around a dual-port register array.
module asynch_fifo
    import asynch_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = asynch_fifo_pkg::DATA_WIDTH,
    parameter int DEPTH      = asynch_fifo_pkg::DEPTH,
    parameter int ADDR_WIDTH = asynch_fifo_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] buf_in,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  buf_full,
    output logic                  buf_empty,
    output logic [ADDR_WIDTH:0]   fifo_counter
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Acceptance uses the flags as they stand before the edge.
    assign w_wr_acc = wr_en && !buf_full;
    assign w_rd_acc = rd_en && !buf_empty;

    assign buf_empty    = (r_count == '0);
    assign buf_full     = (r_count == FULL_CNT);
    assign fifo_counter = r_count;

    // Advance pointers on accepted operations and track occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (w_wr_acc),
        .waddr(r_wr_ptr),
        .wdata(buf_in),
        .re   (w_rd_acc),
        .raddr(r_rd_ptr),
        .rdata(buf_out)
    );

endmodule

// File: tb/tb_asynch_fifo.sv
// Scoreboard bench for asynch_fifo: stimulus updates a queue-based reference
// model and pushes expected read words; a monitor pops and compares them.
module tb_asynch_fifo;

    localparam int DW = 8;
    localparam int DP = 64;
    localparam int AW = 6;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] buf_in;
    logic [DW-1:0] buf_out;
    logic          buf_full;
    logic          buf_empty;
    logic [AW:0]   fifo_counter;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_out;
    logic          mon_took;
    logic [DW-1:0] saved;

    asynch_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DP),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .buf_in      (buf_in),
        .buf_out     (buf_out),
        .buf_full    (buf_full),
        .buf_empty   (buf_empty),
        .fifo_counter(fifo_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference model decides acceptance from its
    // occupancy before the edge, then the status outputs are compared.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
        logic acc_w;
        logic acc_r;
        @(negedge clk);
        wr_en  = w;
        rd_en  = r;
        buf_in = d;
        acc_r  = r && (model.size() != 0);
        acc_w  = w && (model.size() != DP);
        if (acc_r) begin
            model_out = model.pop_front();
            exp_q.push_back(model_out);
        end
        if (acc_w) model.push_back(d);
        @(posedge clk);
        #1;
        chk("count", int'(fifo_counter), model.size());
        chk("empty", int'(buf_empty), int'(model.size() == 0));
        chk("full", int'(buf_full), int'(model.size() == DP));
        chk("buf_out_hold", int'(buf_out), int'(model_out));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0);
    endtask

    // Monitor: whenever the DUT takes a read, the next word on buf_out must be
    // the oldest expected word.
    always @(posedge clk) begin
        mon_took = rst && rd_en && !buf_empty;
        if (mon_took) begin
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got %0h expected no read", buf_out);
            end else begin
                chk("rd_data", int'(buf_out), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        buf_in    = '0;
        model_out = '0;

        // Reset then idle.
        #49;
        chk("rst_empty", int'(buf_empty), 1);
        chk("rst_full", int'(buf_full), 0);
        chk("rst_count", int'(fifo_counter), 0);
        chk("rst_out", int'(buf_out), 0);
        #1 rst = 1'b1;
        idle();

        // Fill with random bytes, then an overflow write of 0xAA.
        for (int i = 0; i < DP; i++) cycle(1'b1, 1'b0, 8'($urandom));
        chk("fill_full", int'(buf_full), 1);
        chk("fill_count", int'(fifo_counter), DP);
        cycle(1'b1, 1'b0, 8'hAA);
        chk("overflow_count", int'(fifo_counter), DP);

        // Drain with rd_en held, then one read while empty.
        for (int i = 0; i < DP; i++) cycle(1'b0, 1'b1, '0);
        chk("drain_empty", int'(buf_empty), 1);
        saved = buf_out;
        cycle(1'b0, 1'b1, '0);
        chk("underflow_hold", int'(buf_out), int'(saved));
        idle();

        // Wrap-around across the pointer boundary.
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, '0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, '0);
        idle();

        // Simultaneous read/write with 10 entries held.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'($urandom));
        chk("simul_count", int'(fifo_counter), 10);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, '0);

        // Simultaneous at full: only the read is accepted.
        for (int i = 0; i < DP; i++) cycle(1'b1, 1'b0, 8'($urandom));
        cycle(1'b1, 1'b1, 8'h3C);
        chk("simul_full_count", int'(fifo_counter), DP - 1);
        for (int i = 0; i < DP - 1; i++) cycle(1'b0, 1'b1, '0);

        // Simultaneous at empty: only the write is accepted, buf_out unchanged.
        saved = buf_out;
        cycle(1'b1, 1'b1, 8'h96);
        chk("simul_empty_count", int'(fifo_counter), 1);
        chk("simul_empty_out", int'(buf_out), int'(saved));
        cycle(1'b0, 1'b1, '0);
        chk("simul_empty_read", int'(buf_out), 8'h96);

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom), 1'($urandom), 8'($urandom));
        while (model.size() != 0) cycle(1'b0, 1'b1, '0);
        idle();

        // Reset mid-stream, pulsed between clock edges.
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 8'($urandom));
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("midrst_empty", int'(buf_empty), 1);
        chk("midrst_full", int'(buf_full), 0);
        chk("midrst_count", int'(fifo_counter), 0);
        chk("midrst_out", int'(buf_out), 0);
        model.delete();
        model_out = '0;
        #1 rst = 1'b1;
        cycle(1'b1, 1'b0, 8'h5C);
        cycle(1'b0, 1'b1, '0);
        chk("post_rst_read", int'(buf_out), 8'h5C);
        idle();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
